fir_tap_sequencer: RTL

//  Control sequencer for the FIR datapath, on the single clk domain.
//  - Loads NTAPS coefficients into the coefficient memory.
//  - Writes each accepted input sample into the circular sample memory.
//  - Sweeps all NTAPS tap pairs into the MAC, one per cycle.
//  - Flags the finished output. Sits between the sample source and the memories/MAC.

---
 rtl/fir_tap_sequencer_if.sv | 47 ++++
 rtl/fir_tap_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample/coefficient handshake plus memory and MAC strobes.
// The sequencer uses the slave modport; the sample/coefficient source uses master.
// Optional: FIR_OVERRUN_CNT_EN adds the overrun_cnt count.
interface fir_tap_sequencer_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
);
  logic          coef_load;
  logic          coef_valid;
  logic [DW-1:0] coef_data;
  logic          samp_valid;
  logic          samp_ready;
  logic [DW-1:0] samp_data;
  logic          cmem_we;
  logic [AW-1:0] cmem_addr;
  logic [DW-1:0] cmem_wdata;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          out_valid;
  logic          busy;
  logic          overrun;
`ifdef FIR_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt;
`endif

  modport slave (
    input  coef_load, coef_valid, coef_data, samp_valid, samp_data,
    output samp_ready, cmem_we, cmem_addr, cmem_wdata, imem_we, imem_addr, imem_wdata,
           mac_en, mac_clr, mac_last, out_valid, busy, overrun
`ifdef FIR_OVERRUN_CNT_EN
    , overrun_cnt
`endif
  );

  modport master (
    output coef_load, coef_valid, coef_data, samp_valid, samp_data,
    input  samp_ready, cmem_we, cmem_addr, cmem_wdata, imem_we, imem_addr, imem_wdata,
           mac_en, mac_clr, mac_last, out_valid, busy, overrun
`ifdef FIR_OVERRUN_CNT_EN
    , overrun_cnt
`endif
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: loads coefficients, writes samples into the circular sample
// memory, sweeps all tap pairs through the MAC and flags each finished output.
// Optional: FIR_OVERRUN_CNT_EN adds a saturating 16-bit dropped-sample counter.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  fir_tap_sequencer_if.slave bus
);

  localparam int unsigned LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [LW-1:0] D_LAST = LW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [LW-1:0] d_q, d_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          coef_ok_q, coef_ok_d;
  logic [DW-1:0] samp_q, samp_d;
  logic          out_valid_q, out_valid_d;

  logic          samp_ready_c;
  logic          cmem_we_c;
  logic [AW-1:0] cmem_addr_c;
  logic [DW-1:0] cmem_wdata_c;
  logic          imem_we_c;
  logic [AW-1:0] imem_addr_c;
  logic [DW-1:0] imem_wdata_c;
  logic          mac_en_c;
  logic          mac_clr_c;
  logic          mac_last_c;
  logic          busy_c;
  logic          overrun_c;

  // State, tap/drain counters, write pointer, coefficient-valid flag, sample latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      d_q         <= '0;
      wr_ptr_q    <= '0;
      coef_ok_q   <= 1'b0;
      samp_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      d_q         <= d_d;
      wr_ptr_q    <= wr_ptr_d;
      coef_ok_q   <= coef_ok_d;
      samp_q      <= samp_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and strobe decode; out_valid is flagged the cycle after the final drain cycle
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    d_d          = d_q;
    wr_ptr_d     = wr_ptr_q;
    coef_ok_d    = coef_ok_q;
    samp_d       = samp_q;
    out_valid_d  = 1'b0;
    samp_ready_c = 1'b0;
    cmem_we_c    = 1'b0;
    cmem_addr_c  = '0;
    cmem_wdata_c = '0;
    imem_we_c    = 1'b0;
    imem_addr_c  = '0;
    imem_wdata_c = '0;
    mac_en_c     = 1'b0;
    mac_clr_c    = 1'b0;
    mac_last_c   = 1'b0;
    busy_c       = (state_q != IDLE);
    overrun_c    = (state_q != IDLE) && coef_ok_q && bus.samp_valid;

    unique case (state_q)
      IDLE: begin
        samp_ready_c = coef_ok_q;
        if (bus.coef_load) begin
          state_d   = LOAD;
          coef_ok_d = 1'b0;
          k_d       = '0;
        end else if (bus.samp_valid && coef_ok_q) begin
          samp_d  = bus.samp_data;
          state_d = WRITE;
        end
      end
      LOAD: begin
        if (bus.coef_valid) begin
          cmem_we_c    = 1'b1;
          cmem_addr_c  = k_q;
          cmem_wdata_c = bus.coef_data;
          k_d          = k_q + 1'b1;
          if (k_q == K_LAST) begin
            coef_ok_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WRITE: begin
        imem_we_c    = 1'b1;
        imem_addr_c  = wr_ptr_q;
        imem_wdata_c = samp_q;
        k_d          = '0;
        state_d      = RUN;
      end
      RUN: begin
        mac_en_c    = 1'b1;
        cmem_addr_c = k_q;
        imem_addr_c = wr_ptr_q - k_q;
        mac_clr_c   = (k_q == '0);
        mac_last_c  = (k_q == K_LAST);
        k_d         = k_q + 1'b1;
        if (k_q == K_LAST) begin
          d_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        d_d = d_q + 1'b1;
        if (d_q == D_LAST) begin
          out_valid_d = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.samp_ready = samp_ready_c;
  assign bus.cmem_we    = cmem_we_c;
  assign bus.cmem_addr  = cmem_addr_c;
  assign bus.cmem_wdata = cmem_wdata_c;
  assign bus.imem_we    = imem_we_c;
  assign bus.imem_addr  = imem_addr_c;
  assign bus.imem_wdata = imem_wdata_c;
  assign bus.mac_en     = mac_en_c;
  assign bus.mac_clr    = mac_clr_c;
  assign bus.mac_last   = mac_last_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_c;
  assign bus.overrun    = overrun_c;

`ifdef FIR_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  // Saturating dropped-sample count, cleared when a coefficient reload is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else if (state_q == IDLE && bus.coef_load) begin
      ovr_cnt_q <= '0;
    end else if (overrun_c && ovr_cnt_q != 16'hFFFF) begin
      ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign bus.overrun_cnt = ovr_cnt_q;
`endif

endmodule
